// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and constants for the two-requester APB master arbiter.
//   arb_state_t : arbiter FSM state (IDLE / ACCESS)
//   req_id_t    : requester index (0 = m0/CPU, 1 = m1/debug-DMA)
//   PRIO_*      : arbitration policy selectors
package apb_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

    typedef logic req_id_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB4 signal bundle used for both requester ports and the interconnect port.
//   master modport : drives the request (paddr..pstrb), receives the response
//   slave  modport : receives the request, drives the response (pready/prdata/pslverr)
interface apb_master_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic                pready;
    logic [DATA_W-1:0]   prdata;
    logic                pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_master_arbiter_picker.sv
// Combinational winner selection for the APB arbiter.
//   psel       : request vector {m1, m0}
//   last_grant : owner of the most recently completed transfer
//   starve_cnt : consecutive m0 grants made while m1 was waiting
//   valid      : at least one requester is asking
//   winner     : requester to grant this cycle
//   starve_nxt : starve_cnt value to load if this grant is taken
module apb_arb_picker
    import apb_arb_pkg::*;
#(
    parameter int PRIO_MODE    = PRIO_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic [1:0] psel,
    input  req_id_t    last_grant,
    input  logic [3:0] starve_cnt,
    output logic       valid,
    output req_id_t    winner,
    output logic [3:0] starve_nxt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    always_comb begin
        valid      = |psel;
        winner     = 1'b0;
        starve_nxt = starve_cnt;

        case (psel)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11: begin
                if (PRIO_MODE == PRIO_RR) begin
                    winner = ~last_grant;
                end else begin
                    // m0 normally wins; m1 breaks through once m0 has had its quota
                    winner = (starve_cnt == LIMIT);
                end
            end
            default: winner = 1'b0;
        endcase

        if (valid) begin
            if (winner) begin
                starve_nxt = 4'd0;
            end else if (psel[1]) begin
                starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
            end else begin
                starve_nxt = 4'd0;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB4 master port between two requesters, one whole transfer at a
// time, with zero added latency and no bubble between back-to-back transfers.
//   pclk, preset_n : clock, synchronous active-low reset
//   m0, m1         : requester ports (m0 = CPU, m1 = debug/DMA)
//   s              : port toward the peripheral interconnect
//   arb_busy       : a transfer is in its ACCESS phase
//   arb_owner      : current (or most recent) owner, 0 = m0
//   proto_err      : one-cycle pulse when the owner drops psel mid-transfer
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | no transfer in ACCESS; a winner, if any, is in SETUP now
// ARB_ACCESS | forwarding owner's transfer until the slave raises pready
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int PRIO_MODE    = PRIO_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    apb_master_arbiter_if.slave  m0,
    apb_master_arbiter_if.slave  m1,
    apb_master_arbiter_if.master s,
    output logic                 arb_busy,
    output req_id_t              arb_owner,
    output logic                 proto_err
);

    arb_state_t state, state_nxt;
    req_id_t    owner;
    req_id_t    last_grant;
    logic [3:0] starve_cnt;
    logic       drop_seen;

    logic       pick_valid;
    req_id_t    pick_winner;
    logic [3:0] starve_nxt;
    req_id_t    src_sel;
    logic       owner_psel;
    logic       m0_done;
    logic       m1_done;

    // Requester penable is not needed: SETUP/ACCESS phasing is regenerated here.
    logic unused_penable;
    assign unused_penable = m0.penable ^ m1.penable;

    apb_arb_picker #(
        .PRIO_MODE    (PRIO_MODE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_picker (
        .psel       ({m1.psel, m0.psel}),
        .last_grant (last_grant),
        .starve_cnt (starve_cnt),
        .valid      (pick_valid),
        .winner     (pick_winner),
        .starve_nxt (starve_nxt)
    );

    assign owner_psel = owner ? m1.psel : m0.psel;

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (pick_valid) state_nxt = ARB_ACCESS;
            ARB_ACCESS: if (s.pready)   state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    // last_grant resets to 1 so that m0 wins the first round-robin tie.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            starve_cnt <= 4'd0;
            drop_seen  <= 1'b0;
        end else if (state == ARB_IDLE) begin
            drop_seen <= 1'b0;
            if (pick_valid) begin
                owner      <= pick_winner;
                starve_cnt <= starve_nxt;
            end
        end else begin
            if (!owner_psel) drop_seen <= 1'b1;
            if (s.pready)    last_grant <= owner;
        end
    end

    always_comb begin
        src_sel   = owner;
        arb_owner = owner;
        s.psel    = 1'b0;
        s.penable = 1'b0;
        case (state)
            ARB_IDLE: begin
                s.psel = pick_valid;
                if (pick_valid) begin
                    src_sel   = pick_winner;
                    arb_owner = pick_winner;
                end else begin
                    src_sel = 1'b0;
                end
            end
            ARB_ACCESS: begin
                s.psel    = 1'b1;
                s.penable = 1'b1;
            end
            default: ;
        endcase

        s.paddr  = src_sel ? m1.paddr  : m0.paddr;
        s.pwrite = src_sel ? m1.pwrite : m0.pwrite;
        s.pwdata = src_sel ? m1.pwdata : m0.pwdata;
        s.pstrb  = src_sel ? m1.pstrb  : m0.pstrb;

        m0_done = (state == ARB_ACCESS) && (owner == 1'b0) && s.pready;
        m1_done = (state == ARB_ACCESS) && (owner == 1'b1) && s.pready;

        m0.pready  = m0_done;
        m0.prdata  = m0_done ? s.prdata : '0;
        m0.pslverr = m0_done & s.pslverr;
        m1.pready  = m1_done;
        m1.prdata  = m1_done ? s.prdata : '0;
        m1.pslverr = m1_done & s.pslverr;

        arb_busy  = (state == ARB_ACCESS);
        proto_err = (state == ARB_ACCESS) && !owner_psel && !drop_seen;
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

    typedef logic [141:0] obs_t;

    logic        pclk;
    logic        preset_n;
    logic [31:0] m0_paddr, m0_pwdata, m1_paddr, m1_pwdata, s_prdata;
    logic [3:0]  m0_pstrb, m1_pstrb;
    logic        m0_psel, m0_penable, m0_pwrite;
    logic        m1_psel, m1_penable, m1_pwrite;
    logic        s_pready, s_pslverr;

    logic busy_a, owner_a, perr_a, busy_b, owner_b, perr_b;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_a ();
    apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_a ();
    apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_a ();
    apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_b ();
    apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_b ();
    apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_b ();

    assign m0_a.paddr = m0_paddr;   assign m0_a.psel = m0_psel;     assign m0_a.penable = m0_penable;
    assign m0_a.pwrite = m0_pwrite; assign m0_a.pwdata = m0_pwdata; assign m0_a.pstrb = m0_pstrb;
    assign m1_a.paddr = m1_paddr;   assign m1_a.psel = m1_psel;     assign m1_a.penable = m1_penable;
    assign m1_a.pwrite = m1_pwrite; assign m1_a.pwdata = m1_pwdata; assign m1_a.pstrb = m1_pstrb;
    assign s_a.pready = s_pready;   assign s_a.prdata = s_prdata;   assign s_a.pslverr = s_pslverr;
    assign m0_b.paddr = m0_paddr;   assign m0_b.psel = m0_psel;     assign m0_b.penable = m0_penable;
    assign m0_b.pwrite = m0_pwrite; assign m0_b.pwdata = m0_pwdata; assign m0_b.pstrb = m0_pstrb;
    assign m1_b.paddr = m1_paddr;   assign m1_b.psel = m1_psel;     assign m1_b.penable = m1_penable;
    assign m1_b.pwrite = m1_pwrite; assign m1_b.pwdata = m1_pwdata; assign m1_b.pstrb = m1_pstrb;
    assign s_b.pready = s_pready;   assign s_b.prdata = s_prdata;   assign s_b.pslverr = s_pslverr;

    // a: round-robin, b: fixed priority with starvation limit 2
    apb_master_arbiter u_dut_a (
        .pclk (pclk), .preset_n (preset_n), .m0 (m0_a), .m1 (m1_a), .s (s_a),
        .arb_busy (busy_a), .arb_owner (owner_a), .proto_err (perr_a)
    );

    apb_master_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(2)) u_dut_b (
        .pclk (pclk), .preset_n (preset_n), .m0 (m0_b), .m1 (m1_b), .s (s_b),
        .arb_busy (busy_b), .arb_owner (owner_b), .proto_err (perr_b)
    );

    obs_t act_a, act_b;
    assign act_a = {s_a.psel, s_a.penable, s_a.paddr, s_a.pwrite, s_a.pwdata, s_a.pstrb,
                    m0_a.pready, m0_a.prdata, m0_a.pslverr, m1_a.pready, m1_a.prdata, m1_a.pslverr,
                    busy_a, owner_a, perr_a};
    assign act_b = {s_b.psel, s_b.penable, s_b.paddr, s_b.pwrite, s_b.pwdata, s_b.pstrb,
                    m0_b.pready, m0_b.prdata, m0_b.pslverr, m1_b.pready, m1_b.prdata, m1_b.pslverr,
                    busy_b, owner_b, perr_b};

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Reference model: one record per DUT describing the transfer in flight.
    bit m_busy [2];
    bit m_own  [2];
    bit m_last [2];
    bit m_drop [2];
    int m_run  [2];

    function automatic bit pick_w(int k, logic [1:0] req);
        if (req == 2'b01) return 1'b0;
        if (req == 2'b10) return 1'b1;
        if (k == 0) return !m_last[k];
        return (m_run[k] == 2);
    endfunction

    function automatic obs_t expect_obs(int k);
        logic [1:0] req;
        bit v, w, src, d0, d1, own_out, perr;
        req = {m1_psel, m0_psel};
        v   = (req != 2'b00);
        w   = pick_w(k, req);
        src = m_busy[k] ? m_own[k] : (v & w);
        d0  = m_busy[k] && !m_own[k] && s_pready;
        d1  = m_busy[k] && m_own[k] && s_pready;
        own_out = m_busy[k] ? m_own[k] : (v ? w : m_own[k]);
        perr = m_busy[k] && !req[m_own[k]] && !m_drop[k];
        return {v | m_busy[k], m_busy[k],
                src ? m1_paddr : m0_paddr, src ? m1_pwrite : m0_pwrite,
                src ? m1_pwdata : m0_pwdata, src ? m1_pstrb : m0_pstrb,
                d0, d0 ? s_prdata : 32'h0, d0 & s_pslverr,
                d1, d1 ? s_prdata : 32'h0, d1 & s_pslverr,
                m_busy[k], own_out, perr};
    endfunction

    task automatic advance(int k);
        logic [1:0] req;
        bit w;
        req = {m1_psel, m0_psel};
        w   = pick_w(k, req);
        if (!preset_n) begin
            m_busy[k] = 0; m_own[k] = 0; m_last[k] = 1; m_drop[k] = 0; m_run[k] = 0;
        end else if (!m_busy[k]) begin
            if (req != 2'b00) begin
                m_busy[k] = 1; m_own[k] = w; m_drop[k] = 0;
                if (k == 1) m_run[k] = w ? 0 : (m1_psel ? ((m_run[k] < 2) ? m_run[k] + 1 : 2) : 0);
            end
        end else begin
            if (!req[m_own[k]]) m_drop[k] = 1;
            if (s_pready) begin
                m_busy[k] = 0; m_last[k] = m_own[k];
            end
        end
    endtask

    always @(negedge pclk) begin
        obs_t e, a;
        for (int k = 0; k < 2; k++) begin
            e = expect_obs(k);
            a = (k == 0) ? act_a : act_b;
            if (chk_on) begin
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL model_cmp dut%0d t=%0t got=%h want=%h", k, $time, a, e);
                end
            end
            advance(k);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic reset_dut();
        m0_psel = 0; m1_psel = 0; m0_penable = 0; m1_penable = 0;
        s_pready = 0; s_pslverr = 0;
        preset_n = 0;
        tick();
        preset_n = 1;
    endtask

    initial begin
        int pen, err, m0r, cnt_p, cnt_s, na, nb;
        logic [3:0] own_seq, rdy_seq;
        logic [5:0] seq_a, seq_b;

        preset_n = 0;
        m0_paddr = 0; m0_pwdata = 0; m0_pstrb = 0; m0_psel = 0; m0_penable = 0; m0_pwrite = 0;
        m1_paddr = 0; m1_pwdata = 0; m1_pstrb = 0; m1_psel = 0; m1_penable = 0; m1_pwrite = 0;
        s_pready = 0; s_prdata = 0; s_pslverr = 0;
        tick();
        tick();
        preset_n = 1;
        chk_on = 1;

        // reset state, no requests
        @(negedge pclk);
        check("rst_idle", 64'({s_a.psel, s_a.penable, busy_a, perr_a, m0_a.pready, m1_a.pready, owner_a}), 64'h0);

        // single zero-wait m0 read
        reset_dut();
        m0_paddr = 32'h0002_8004; m0_pwrite = 0; m0_psel = 1;
        s_pready = 1; s_prdata = 32'hDEAD_BEEF;
        @(negedge pclk);
        check("rd_setup_psel", 64'(s_a.psel), 64'h1);
        check("rd_setup_pen", 64'(s_a.penable), 64'h0);
        check("rd_setup_addr", 64'(s_a.paddr), 64'h0002_8004);
        tick();
        m0_penable = 1;
        @(negedge pclk);
        check("rd_access_pen", 64'(s_a.penable), 64'h1);
        check("rd_m0_pready", 64'(m0_a.pready), 64'h1);
        check("rd_m0_prdata", 64'(m0_a.prdata), 64'hDEAD_BEEF);
        check("rd_m1_pready", 64'(m1_a.pready), 64'h0);
        tick();
        m0_psel = 0; m0_penable = 0;

        // simultaneous requests, round-robin
        reset_dut();
        m0_psel = 1; m1_psel = 1; s_pready = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge pclk);
            own_seq[c] = owner_a;
            rdy_seq[c] = m1_a.pready;
            tick();
            if (c == 1) m0_psel = 0;
        end
        m1_psel = 0;
        check("rr_owner_seq", 64'(own_seq), 64'hC);
        check("rr_m1_pready_seq", 64'(rdy_seq), 64'h8);

        // continuous requests from both: grant order per policy
        reset_dut();
        m0_psel = 1; m1_psel = 1; s_pready = 1;
        na = 0; nb = 0; seq_a = 0; seq_b = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge pclk);
            if (s_a.psel && !s_a.penable && na < 6) begin seq_a[na] = owner_a; na++; end
            if (s_b.psel && !s_b.penable && nb < 6) begin seq_b[nb] = owner_b; nb++; end
            tick();
        end
        m0_psel = 0; m1_psel = 0;
        check("fixed_grant_order", 64'(seq_b), 64'h24);
        check("rr_grant_order", 64'(seq_a), 64'h2A);

        // m1 transfer with 3 wait states and error, m0 blocked
        reset_dut();
        m1_psel = 1; m1_paddr = 32'h0003_0000; m1_pwrite = 1; s_pready = 0; s_pslverr = 1;
        pen = 0; err = 0; m0r = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge pclk);
            pen += int'(s_a.penable);
            err += int'(m1_a.pslverr);
            m0r += int'(m0_a.pready);
            tick();
            if (c == 0) begin m0_psel = 1; m1_penable = 1; end
            if (c == 3) s_pready = 1;
        end
        s_pslverr = 0; m1_psel = 0; m1_penable = 0;
        tick();
        tick();
        m0_psel = 0;
        check("ws_penable_cycles", 64'(pen), 64'd4);
        check("ws_m1_pslverr_cycles", 64'(err), 64'd1);
        check("ws_m0_blocked", 64'(m0r), 64'd0);

        // reset asserted mid-transfer
        reset_dut();
        m0_psel = 1; s_pready = 0;
        tick();
        preset_n = 0;
        @(negedge pclk);
        check("mid_rst_busy_before", 64'(busy_a), 64'h1);
        tick();
        preset_n = 1; m0_psel = 0;
        @(negedge pclk);
        check("mid_rst_psel", 64'(s_a.psel), 64'h0);
        check("mid_rst_busy", 64'(busy_a), 64'h0);
        tick();
        m1_psel = 1; s_pready = 1;
        @(negedge pclk);
        check("post_rst_m1_owner", 64'(owner_a), 64'h1);
        tick();
        @(negedge pclk);
        check("post_rst_m1_pready", 64'(m1_a.pready), 64'h1);
        tick();
        m0_psel = 1;
        @(negedge pclk);
        check("post_rst_tie_m0", 64'(owner_a), 64'h0);
        tick();
        tick();
        m0_psel = 0; m1_psel = 0;

        // owner drops psel while the slave stalls
        reset_dut();
        m0_psel = 1; s_pready = 0;
        tick();
        m0_psel = 0;
        cnt_p = 0; cnt_s = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge pclk);
            cnt_p += int'(perr_a);
            cnt_s += int'(s_a.psel);
            tick();
            if (c == 2) s_pready = 1;
        end
        @(negedge pclk);
        check("drop_proto_pulses", 64'(cnt_p), 64'd1);
        check("drop_psel_held", 64'(cnt_s), 64'd4);
        check("drop_back_idle", 64'({s_a.psel, busy_a}), 64'h0);

        // randomized traffic against the model
        reset_dut();
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(7) == 0) m0_psel = ~m0_psel;
            if ($urandom_range(7) == 0) m1_psel = ~m1_psel;
            m0_paddr = $urandom; m0_pwdata = $urandom; m0_pstrb = 4'($urandom_range(15));
            m0_pwrite = 1'($urandom_range(1)); m0_penable = 1'($urandom_range(1));
            m1_paddr = $urandom; m1_pwdata = $urandom; m1_pstrb = 4'($urandom_range(15));
            m1_pwrite = 1'($urandom_range(1)); m1_penable = 1'($urandom_range(1));
            s_pready = ($urandom_range(2) != 0);
            s_prdata = $urandom;
            s_pslverr = ($urandom_range(3) == 0);
            preset_n = ($urandom_range(63) != 0);
        end
        preset_n = 1; m0_psel = 0; m1_psel = 0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares the single APB4 master port of the peripheral interconnect between two requesters: m0 (CPU) and m1 (debug/DMA port).
- Grants one whole APB transfer at a time (SETUP to the completing ACCESS) and forwards it unchanged to the interconnect.
- Routes the response back to the owner only; the non-owner sees wait states.
- Adds zero latency when the bus is idle and there is no bubble between back-to-back transfers.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority m0 with starvation guard.
- STARVE_LIMIT, 4, in PRIO_MODE=1: maximum consecutive m0 grants while m1 is requesting; range 1..15.

Ports:
- pclk  in  1  clock; all state updates on the rising edge.
- preset_n  in  1  reset, synchronous, active-low.
- m0_paddr, m0_psel, m0_penable, m0_pwrite, m0_pwdata, m0_pstrb  in  ADDR_W/1/1/1/DATA_W/DATA_W/8  requester 0 APB4 request.
- m0_pready, m0_prdata, m0_pslverr  out  1/DATA_W/1  requester 0 response.
- m1_* (same signal set)  in/out  same widths  requester 1.
- s_paddr, s_psel, s_penable, s_pwrite, s_pwdata, s_pstrb  out  as above  to the interconnect master port.
- s_pready, s_prdata, s_pslverr  in  1/DATA_W/1  from the interconnect.
- arb_busy  out  1  FSM in ACCESS.
- arb_owner  out  1  current or most recent owner (0 = m0).
- proto_err  out  1  one-cycle pulse when the owner drops psel before completion.

Behaviour:
- FSM states: IDLE, ACCESS. Registers:
  - state
  - owner (1b)
  - last_grant (1b)
  - starve_cnt (4b)
- Reset (preset_n low at a clock edge):
  - state = IDLE, owner = 0, last_grant = 1 (so m0 wins the first round-robin tie), starve_cnt = 0.
  - Outputs are combinational from state. While in IDLE with no request: s_psel = 0, s_penable = 0, all m*_pready/prdata/pslverr = 0, arb_busy = 0, proto_err = 0.
  - Reset asserted mid-transfer: the FSM returns to IDLE at that edge. The aborted transfer is neither completed nor reported.
- IDLE:
  - A winner is picked combinationally from {m0_psel, m1_psel}, regardless of the requester's penable.
  - If there is a winner: s_psel = 1, s_penable = 0, and s_paddr/pwrite/pwdata/pstrb come from the winner. Next state = ACCESS, owner <= winner.
  - With no request, s_paddr/pwdata/pstrb/pwrite are driven from m0 (don't-care, but deterministic).
- ACCESS:
  - s_psel = 1, s_penable = 1; request signals come from owner.
  - If s_pready = 1: owner's pready = 1, prdata = s_prdata, pslverr = s_pslverr; last_grant <= owner; next state = IDLE.
  - Otherwise the FSM stays in ACCESS.
- Non-owner response is always pready = 0, prdata = 0, pslverr = 0. A waiting requester is therefore held in wait states. APB already obliges it to keep its request stable.
- Round-robin (PRIO_MODE=0): if both request, grant !last_grant; otherwise grant the single requester.
- Fixed priority (PRIO_MODE=1): m0 wins ties, except that m1 wins when starve_cnt == STARVE_LIMIT.
  - starve_cnt increments on each m0 grant made while m1_psel = 1, saturating at STARVE_LIMIT.
  - starve_cnt clears on any m1 grant, or when an m0 grant is made with m1_psel = 0.
- Back-to-back: a completion returns the FSM to IDLE, and the next cycle's IDLE issues the new SETUP (2 cycles per zero-wait transfer, the same as native APB).
- Owner drops psel while in ACCESS (protocol violation):
  - Forwarding continues with the latched owner until s_pready; the response is still driven to the owner's ports.
  - proto_err pulses once, on the first such cycle.
- Simultaneous completion of owner and new request from the other requester: handled by the next IDLE cycle; no request is lost.

Decomposition:
- Package apb_arb_pkg:
  - state enum (ARB_IDLE, ARB_ACCESS)
  - requester id type (req_id_t, 1b)
  - policy constants (PRIO_RR = 0, PRIO_FIXED = 1)
- Sub-module apb_arb_picker: combinational winner selection plus next starve_cnt value.
  - Inputs: psel vector, last_grant, starve_cnt, PRIO_MODE.
  - Outputs: valid, winner.
  - The FSM and muxing stay in the top module.

Test Plan:
- Single m0 read of 0x0002_8004, slave zero-wait with prdata = 0xDEADBEEF -> s_psel high on cycle 0, s_penable high on cycle 1, m0_prdata = 0xDEADBEEF with m0_pready on cycle 1; m1_pready stays 0.
- m0 and m1 both assert psel in the same cycle, PRIO_MODE=0, after reset -> m0 is granted first. m1 sees 2 cycles of pready = 0, then its transfer completes on cycles 2-3; arb_owner sequence 0,0,1,1.
- PRIO_MODE=1, STARVE_LIMIT=2, m0 issues continuous back-to-back writes, m1 requests continuously -> grant order m0, m0, m1, m0, m0, m1.
- Owner m1 transfer with slave inserting 3 wait states and pslverr = 1 (unmapped 0x0003_0000) -> s_penable held 4 cycles, m1_pslverr = 1 only on the pready cycle, m0 blocked throughout.
- preset_n driven low during ACCESS -> next cycle s_psel = 0, arb_busy = 0. After release, a fresh m1 request is granted (last_grant = 1 means a round-robin tie now goes to m0).
- m0 deasserts psel while in ACCESS with slave stalling -> proto_err single-cycle pulse, s_psel remains 1 until s_pready, then the FSM returns to IDLE.
